tpu_mac_sequencer: RTL and testbench
====================================

# tpu_mac_sequencer

Sequencer that drives the TPU minifloat multiply-accumulate unit through one dot-product job. Accepts a start command with a vector length and streams 8-bit minifloat operand pairs (1 sign, 4 exponent, 3 mantissa) from an operand source. Generates the unit's clear, `sync` and `out_HL` controls, and reads back the 32-bit accumulator as two 16-bit halves. Sits between the host/operand buffer and the MAC datapath; one instance per MAC unit.

## Interface
- `LEN_W`, 16, width of job length.
- `SETUP_CYCLES`, 1, cycles operands are held stable before the `sync` pulse (≥1).
- `CLEAR_CYCLES`, 1, cycles `mac_reset` is held high at job start (≥1).

- `clk` input 1 — single clock; all logic on rising edge.
- `reset` input 1 — asynchronous, active-low.
- `start` input 1 — job request; sampled only in IDLE.
- `len` input LEN_W — operand-pair count, latched with `start`.
- `op_valid` input 1 — operand pair available.
- `op_a`, `op_b` input 8 each — minifloat operands.
- `op_ready` output 1 — pair consumed on `op_valid && op_ready`.
- `mac_reset` output 1 — active-high clear to the MAC.
- `mac_sync` output 1 — multiply strobe.
- `mac_in1`, `mac_in2` output 8 each — registered operands.
- `mac_out_HL` output 1 — 0 selects accumulator[15:0], 1 selects [31:16].
- `mac_ready`, `mac_error` input 1 each — MAC status.
- `mac_out` input 16 — MAC result half.
- `busy` output 1 — job in progress.
- `done` output 1 — one-cycle completion pulse.
- `err` output 1 — sticky job error.
- `result` output 32 — accumulator snapshot.

## Operation
- States: IDLE, CLEAR, WAITRDY, FETCH, SETUP, PULSE, HOLD, READ_LO, READ_HI, DONE.
- IDLE: `busy`=0. On `start`, latch `len` into `remaining` and clear `err`.
  - If `len`==0: go directly to DONE with `result`=0 and no MAC activity.
  - Otherwise go to CLEAR.
- CLEAR: `mac_reset`=1 for CLEAR_CYCLES, then WAITRDY.
- WAITRDY: `mac_reset`=0. Stay until `mac_ready`=1, minimum 1 cycle.
- FETCH: `op_ready`=1. On handshake, register `op_a`/`op_b` into `mac_in1`/`mac_in2`, go to SETUP.
- SETUP: hold the operands for SETUP_CYCLES, then PULSE.
- PULSE: `mac_sync`=1 for exactly one cycle; decrement `remaining`; go to HOLD.
- HOLD: `mac_sync`=0 for one cycle.
  - If `remaining`≠0: go to FETCH.
  - Otherwise: go to READ_LO.
- READ_LO: `mac_out_HL`=0; capture `mac_out` into `result[15:0]` at the end of the cycle.
- READ_HI: `mac_out_HL`=1; capture into `result[31:16]`.
- DONE: `done`=1 for one cycle, return to IDLE. `result` holds until the next job completes.
- Error handling:
  - `mac_error` is sampled in PULSE and HOLD.
  - If it is 1: set `err`, skip READ_LO/READ_HI (`result` keeps its previous value), go to DONE.
- `start` outside IDLE is ignored.
- `mac_in1`/`mac_in2` change only on a FETCH handshake.
- `remaining` is an LEN_W-bit down-counter and never wraps; it is only decremented when nonzero.

## Timing
- Reset values:
  - `op_ready`=0, `mac_sync`=0, `mac_in1`=`mac_in2`=0.
  - `mac_out_HL`=0, `busy`=0, `done`=0, `err`=0, `result`=0.
  - `mac_reset`=1, so the MAC is cleared while the sequencer is held in reset. Any job in flight is abandoned.
- First clock edge after reset deassertion: `mac_reset` goes to 0, state is IDLE.
- `busy`=1 in every state except IDLE.
- Latency with `op_valid` held high and `mac_ready`=1: `done` asserts CLEAR_CYCLES + 1 + N·(SETUP_CYCLES+3) + 3 cycles after the edge that samples `start`. Defaults with N=4: 21 cycles.
- `op_valid` low in FETCH stalls the job indefinitely; all other outputs hold.
- The `mac_sync` rising edge always follows ≥SETUP_CYCLES cycles of stable operands. `mac_sync` is low for ≥2 cycles between pulses.

## Configuration
- `TPU_SEQ_ERR_FLUSH_EN` defined: on error, enter a FLUSH state with `op_ready`=1. Drain the remaining pairs (decrement per handshake, no `mac_sync`), then go to DONE. The operand source stays aligned for the next job.
- Not defined: on error, go straight to DONE. Unconsumed pairs stay in the source.

## Test plan
- Stub MAC drives `mac_out`=16'h1234 when HL=0 and 16'hBEEF when HL=1; `len`=4, `op_valid`=1 → exactly 4 `mac_sync` pulses, `done` 21 cycles after `start`, `result`=32'hBEEF1234, `err`=0.
- Pairs (8'h38,8'h40),(8'hB8,8'h41) → `mac_in1`/`mac_in2` equal each pair for ≥1 cycle before and during the matching `mac_sync`.
- `len`=0 → `done` 1 cycle after IDLE exit, `result`=0, no `mac_reset`/`mac_sync` activity.
- `mac_error`=1 during the 2nd pulse of a `len`=5 job → `err`=1, `result` unchanged, `done` pulses.
  - Flush build: 3 further handshakes.
  - Non-flush build: 0 further handshakes.
- `op_valid` dropped for 10 cycles mid-job, plus `start` re-asserted while busy → latency grows by 10 cycles, second `start` ignored.
- `reset` asserted in SETUP → all outputs reach reset values immediately, `mac_reset`=1; a new job after release completes normally.

Source files
------------

// File: rtl/tpu_mac_sequencer.sv
// Sequences one minifloat dot-product job through the TPU MAC: clear, operand fetch, sync strobes, 32-bit readback.
// Optional TPU_SEQ_ERR_FLUSH_EN: after a MAC error, drain the job's remaining operand pairs before finishing.
module tpu_mac_sequencer #(
    parameter int LEN_W        = 16,
    parameter int SETUP_CYCLES = 1,
    parameter int CLEAR_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             op_valid,
    input  logic [7:0]       op_a,
    input  logic [7:0]       op_b,
    output logic             op_ready,
    output logic             mac_reset,
    output logic             mac_sync,
    output logic [7:0]       mac_in1,
    output logic [7:0]       mac_in2,
    output logic             mac_out_HL,
    input  logic             mac_ready,
    input  logic             mac_error,
    input  logic [15:0]      mac_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      result,
    output logic [3:0]       state_dbg
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] CLEAR   = 4'd1;
    localparam logic [3:0] WAITRDY = 4'd2;
    localparam logic [3:0] FETCH   = 4'd3;
    localparam logic [3:0] SETUP   = 4'd4;
    localparam logic [3:0] PULSE   = 4'd5;
    localparam logic [3:0] HOLD    = 4'd6;
    localparam logic [3:0] READ_LO = 4'd7;
    localparam logic [3:0] READ_HI = 4'd8;
    localparam logic [3:0] DONE    = 4'd9;
`ifdef TPU_SEQ_ERR_FLUSH_EN
    localparam logic [3:0] FLUSH   = 4'd10;
`endif

    localparam int CNT_MAX = (SETUP_CYCLES > CLEAR_CYCLES) ? SETUP_CYCLES : CLEAR_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);

    logic [3:0]       state, state_n, err_target;
    logic [CNT_W-1:0] cnt;
    logic [LEN_W-1:0] remaining, rem_dec;

    // Operand handshake: a pair transfers on a rising edge where op_valid && op_ready;
    // op_ready never depends combinationally on op_valid.
    assign rem_dec   = (remaining != '0) ? remaining - 1'b1 : remaining;
    assign state_dbg = state;

    always_comb begin
        err_target = DONE;
`ifdef TPU_SEQ_ERR_FLUSH_EN
        // PULSE has already consumed one pair this cycle, so look at the decremented count.
        if (state == PULSE) err_target = (rem_dec != '0) ? FLUSH : DONE;
        else                err_target = (remaining != '0) ? FLUSH : DONE;
`endif
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (len == '0) ? DONE : CLEAR;
            CLEAR:   if (cnt == CLEAR_LAST) state_n = WAITRDY;
            WAITRDY: if (mac_ready) state_n = FETCH;
            FETCH:   if (op_valid) state_n = SETUP;
            SETUP:   if (cnt == SETUP_LAST) state_n = PULSE;
            PULSE:   state_n = mac_error ? err_target : HOLD;
            HOLD: begin
                if (mac_error)              state_n = err_target;
                else if (remaining != '0)   state_n = FETCH;
                else                        state_n = READ_LO;
            end
            READ_LO: state_n = READ_HI;
            READ_HI: state_n = DONE;
            DONE:    state_n = IDLE;
`ifdef TPU_SEQ_ERR_FLUSH_EN
            FLUSH: begin
                if (remaining == '0)                      state_n = DONE;
                else if (op_valid && remaining == LEN_W'(1)) state_n = DONE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            remaining <= '0;
        end else begin
            state <= state_n;
            if (state_n != state)                  cnt <= '0;
            else if (state == CLEAR || state == SETUP) cnt <= cnt + 1'b1;
            if (state == IDLE && start)            remaining <= len;
            else if (state == PULSE)               remaining <= rem_dec;
`ifdef TPU_SEQ_ERR_FLUSH_EN
            else if (state == FLUSH && op_valid)   remaining <= rem_dec;
`endif
        end
    end

    // Control outputs are registered decodes of the next state, so they line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_ready   <= 1'b0;
            mac_reset  <= 1'b1;
            mac_sync   <= 1'b0;
            mac_out_HL <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
`ifdef TPU_SEQ_ERR_FLUSH_EN
            op_ready   <= (state_n == FETCH) || (state_n == FLUSH);
`else
            op_ready   <= (state_n == FETCH);
`endif
            mac_reset  <= (state_n == CLEAR);
            mac_sync   <= (state_n == PULSE);
            mac_out_HL <= (state_n == READ_HI);
            busy       <= (state_n != IDLE);
            done       <= (state_n == DONE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mac_in1 <= 8'h00;
            mac_in2 <= 8'h00;
            err     <= 1'b0;
            result  <= 32'h0;
        end else begin
            if (state == FETCH && op_valid) begin
                mac_in1 <= op_a;
                mac_in2 <= op_b;
            end
            if (state == IDLE && start)                          err <= 1'b0;
            else if ((state == PULSE || state == HOLD) && mac_error) err <= 1'b1;
            if (state == IDLE && start && len == '0) result <= 32'h0;
            else if (state == READ_LO)               result[15:0]  <= mac_out;
            else if (state == READ_HI)               result[31:16] <= mac_out;
        end
    end

endmodule

// File: tb/tb_tpu_mac_sequencer.sv
// Directed bench for tpu_mac_sequencer with a stub MAC, an operand source model and result/operand scoreboards.
// Honours TPU_SEQ_ERR_FLUSH_EN for the expected drain count after a MAC error.
module tb_tpu_mac_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] len;
    logic        op_valid;
    logic [7:0]  op_a, op_b;
    logic        op_ready, mac_reset, mac_sync, mac_out_HL;
    logic [7:0]  mac_in1, mac_in2;
    logic        mac_ready, mac_error;
    logic [15:0] mac_out;
    logic        busy, done, err;
    logic [31:0] result;
    logic [3:0]  state_dbg;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tpu_mac_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
        .mac_reset(mac_reset), .mac_sync(mac_sync), .mac_in1(mac_in1), .mac_in2(mac_in2),
        .mac_out_HL(mac_out_HL), .mac_ready(mac_ready), .mac_error(mac_error), .mac_out(mac_out),
        .busy(busy), .done(done), .err(err), .result(result), .state_dbg(state_dbg)
    );

    // Stub MAC readback and operand source.
    logic [15:0] lo_val = 16'h1234;
    logic [15:0] hi_val = 16'hBEEF;
    assign mac_out = mac_out_HL ? hi_val : lo_val;

    logic [7:0] src_a [64];
    logic [7:0] src_b [64];
    logic [5:0] src_idx = '0;
    assign op_a = src_a[src_idx];
    assign op_b = src_b[src_idx];

    logic [32:0] exp_q[$];
    logic [15:0] exp_op_q[$];

    int cyc = 0, hs_cnt = 0, sync_cnt = 0, done_cnt = 0, mac_reset_cnt = 0, done_cyc = 0;
    int low_run = 99;
    logic sync_prev = 1'b0;
    logic [15:0] prev_in = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && op_valid && op_ready) begin
            exp_op_q.push_back({src_a[src_idx], src_b[src_idx]});
            src_idx <= src_idx + 1'b1;
            hs_cnt  <= hs_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (mac_reset) mac_reset_cnt <= mac_reset_cnt + 1;
            if (mac_sync && !sync_prev) begin
                sync_cnt <= sync_cnt + 1;
                check("sync_low_gap", 64'(low_run >= 2), 64'd1);
                check("sync_pair_avail", 64'(exp_op_q.size() != 0), 64'd1);
                if (exp_op_q.size() != 0) begin
                    logic [15:0] e;
                    e = exp_op_q.pop_front();
                    check("sync_operands", 64'({mac_in1, mac_in2}), 64'(e));
                    check("setup_operands", 64'(prev_in), 64'(e));
                end
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
                check("done_job_avail", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("done_err_result", 64'({err, result}), 64'(e));
                end
            end
        end
        low_run   <= mac_sync ? 0 : low_run + 1;
        sync_prev <= mac_sync;
        prev_in   <= {mac_in1, mac_in2};
    end

    int start_cyc, done0, sync0, rst0, hs0;

    task automatic launch(input logic [15:0] l, input logic [32:0] exp);
        @(negedge clk); #1;
        start_cyc = cyc; done0 = done_cnt; sync0 = sync_cnt; rst0 = mac_reset_cnt; hs0 = hs_cnt;
        exp_q.push_back(exp);
        start = 1'b1;
        len   = l;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        while (done_cnt == done0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        check("done_timeout", 64'(done_cnt != done0), 64'd1);
        lat = done_cyc - start_cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op_ready"}, 64'(op_ready), 64'd0);
        check({tag, "_mac_sync"}, 64'(mac_sync), 64'd0);
        check({tag, "_mac_in"}, 64'({mac_in1, mac_in2}), 64'd0);
        check({tag, "_out_HL"}, 64'(mac_out_HL), 64'd0);
        check({tag, "_busy_done_err"}, 64'({busy, done, err}), 64'd0);
        check({tag, "_result"}, 64'(result), 64'd0);
        check({tag, "_mac_reset"}, 64'(mac_reset), 64'd1);
    endtask

    initial begin
        int lat, n, hs_err;
        src_a[0] = 8'h38; src_b[0] = 8'h40;
        src_a[1] = 8'hB8; src_b[1] = 8'h41;
        for (int i = 2; i < 64; i++) begin
            src_a[i] = 8'($urandom_range(0, 255));
            src_b[i] = 8'($urandom_range(0, 255));
        end
        reset = 1'b0; start = 1'b0; len = '0; op_valid = 1'b0;
        mac_ready = 1'b1; mac_error = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_reset_mac_reset", 64'(mac_reset), 64'd0);
        check("post_reset_state", 64'(state_dbg), 64'd0);
        op_valid = 1'b1;

        // Nominal 4-pair job with the two named operand pairs first.
        launch(16'd4, {1'b0, 32'hBEEF1234});
        wait_done(lat);
        check("nominal_latency", 64'(lat), 64'd21);
        check("nominal_syncs", 64'(sync_cnt - sync0), 64'd4);
        check("nominal_clear_cycles", 64'(mac_reset_cnt - rst0), 64'd1);

        // Zero-length job: immediate completion, no MAC activity, result forced to 0.
        launch(16'd0, {1'b0, 32'h0});
        wait_done(lat);
        check("len0_latency", 64'(lat), 64'd1);
        check("len0_syncs", 64'(sync_cnt - sync0), 64'd0);
        check("len0_mac_reset", 64'(mac_reset_cnt - rst0), 64'd0);
        check("len0_handshakes", 64'(hs_cnt - hs0), 64'd0);

        // Stall 10 cycles in the second FETCH, with a start retry while busy.
        launch(16'd4, {1'b0, 32'hBEEF1234});
        n = 0;
        while (!((sync_cnt - sync0) == 1 && op_ready) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("stall_reach_fetch", 64'(op_ready), 64'd1);
        op_valid = 1'b0;
        start = 1'b1; len = 16'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (i == 5) check("stall_mac_in_hold", 64'({mac_in1, mac_in2}), 64'({src_a[0], src_b[0]}) ^ 64'({src_a[0], src_b[0]}) ^ 64'(prev_in));
        end
        op_valid = 1'b1;
        wait_done(lat);
        check("stall_latency", 64'(lat), 64'd31);
        repeat (30) @(negedge clk);
        #1;
        check("busy_start_ignored_done", 64'(done_cnt - done0), 64'd1);
        check("busy_start_ignored_busy", 64'(busy), 64'd0);

        // MAC error on the 2nd pulse of a 5-pair job; readback values changed to expose a stray read.
        lo_val = 16'hAAAA; hi_val = 16'h5555;
        launch(16'd5, {1'b1, 32'hBEEF1234});
        n = 0;
        while ((sync_cnt - sync0) != 2 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("err_reach_pulse2", 64'(mac_sync), 64'd1);
        hs_err = hs_cnt;
        mac_error = 1'b1;
        @(negedge clk); #1;
        mac_error = 1'b0;
        wait_done(lat);
`ifdef TPU_SEQ_ERR_FLUSH_EN
        check("err_drain_handshakes", 64'(hs_cnt - hs_err), 64'd3);
`else
        check("err_drain_handshakes", 64'(hs_cnt - hs_err), 64'd0);
`endif
        check("err_syncs", 64'(sync_cnt - sync0), 64'd2);
        repeat (3) @(negedge clk);
        check("err_sticky", 64'(err), 64'd1);
        exp_op_q.delete();
        lo_val = 16'h1234; hi_val = 16'hBEEF;

        // Next job clears err.
        launch(16'd2, {1'b0, 32'hBEEF1234});
        wait_done(lat);
        check("recover_latency", 64'(lat), 64'd13);

        // Reset asserted in SETUP abandons the job.
        launch(16'd3, {1'b0, 32'hBEEF1234});
        n = 0;
        while (state_dbg != 4'd4 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("reach_setup", 64'(state_dbg), 64'd4);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_job_reset");
        exp_q.delete();
        exp_op_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        launch(16'd4, {1'b0, 32'hBEEF1234});
        wait_done(lat);
        check("post_reset_latency", 64'(lat), 64'd21);
        check("post_reset_syncs", 64'(sync_cnt - sync0), 64'd4);

        repeat (5) @(negedge clk);
        check("jobs_outstanding", 64'(exp_q.size()), 64'd0);
        check("pairs_outstanding", 64'(exp_op_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
